dense_bias_act_64: RTL and testbench
====================================

Name: dense_bias_act_64

Overview:
- Post-processing stage directly downstream of the 1x784 x 784x64 dense PE array.
- Captures the 1x64 partial-sum vector when the array raises its finish level, then adds a per-column bias, applies ReLU, arithmetic-shifts and saturates each element.
- Emits the resulting 1x64 activation vector with a valid/ready handshake toward the next layer (64x10).
- Processing is lane-serialised (LANES elements per cycle) to bound adder count.

Parameters:
- DW, 16, signed element width of psum, bias and output.
- N, 64, vector length.
- LANES, 8, elements processed per cycle; N must be divisible by LANES.
- SHIFT, 4, arithmetic right shift applied after bias add and ReLU.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_finish  in  1  finish level from upstream array; a capture triggers on its rising edge.
- in_psum  in  N*DW  upstream psum vector; element i at bits [DW*i+DW-1 : DW*i], signed.
- bias  in  N*DW  bias vector, same packing; sampled together with in_psum.
- out_data  out  N*DW  activation vector, same packing.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high in PROC or DONE.
- overrun  out  1  sticky; set when an in_finish rising edge arrives while busy.

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, overrun=0; state=IDLE, group counter=0, finish_q=0.
- finish_q is a registered copy of in_finish. Rise = in_finish & ~finish_q. A level held high does not retrigger.
- IDLE:
  - On rise at edge T, latch in_psum and bias into internal buffers, clear group counter g, go to PROC.
  - out_data holds its previous value.
- PROC:
  - Each cycle, process elements g*LANES .. g*LANES+LANES-1 into out_data, then g++.
  - After group G-1 (G=N/LANES), go to DONE.
  - Groups are processed on edges T+1 .. T+G; out_valid=1 from edge T+G+1.
  - Latency is G+1 cycles: 9 with defaults.
- Per element:
  - s = sext(psum)+sext(bias), DW+1 bits.
  - r = (s<0) ? 0 : s.
  - q = r >>> SHIFT.
  - out = (q > 2^(DW-1)-1) ? 2^(DW-1)-1 : q.
  - Output is never negative.
- DONE:
  - out_valid=1 and out_data stable.
  - On out_valid & out_ready: out_valid=0 next cycle, go to IDLE. An IDLE rise in that same cycle is not possible, because state is still DONE.
- A rise while in PROC or DONE is ignored (buffers are not reloaded) and sets overrun. overrun clears only on rst.
- in_psum and bias are sampled only at capture; later changes have no effect.
- rst mid-PROC or mid-DONE: return to IDLE and all outputs go to their reset values next edge. The in-flight vector is discarded.
- out_ready high while not valid: no effect.

Optional Feature:
- Macro: DENSE_ARGMAX_EN.
- When defined:
  - Adds output argmax_idx (6 bits, log2 N), reset 0.
  - A running max/index register updates per group during PROC, using the saturated output values. Ties keep the lowest index.
  - argmax_idx is valid together with out_valid.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package dense_pkg: DW, N and LANES defaults; state enum {IDLE, PROC, DONE}; constant OUT_MAX = 2^(DW-1)-1.
- One sub-module, bias_relu_sat: a combinational per-element bias add, ReLU, shift and saturate. It is instantiated LANES times inside a generate loop.

Test Plan:
- Basic:
  - Stimulus: all psum=100, bias=28, SHIFT=4, rise at T, out_ready=1.
  - Response: out_valid at T+9; every element =8; out_valid drops the cycle after the handshake.
- ReLU/saturation:
  - Stimulus: psum[0]=-50, bias[0]=10; psum[1]=32767, bias[1]=32767.
  - Response: out[0]=0; out[1]=4095 (65534>>>4).
- Level/overrun:
  - Stimulus: hold in_finish high 20 cycles.
  - Response: exactly one capture, overrun=0.
  - Stimulus: then drop in_finish and raise it again during DONE.
  - Response: overrun=1, out_data unchanged.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after valid.
  - Response: out_valid and out_data stable throughout; accepted on the first ready cycle.
- Reset mid-operation:
  - Stimulus: assert rst at T+3 during PROC.
  - Response: out_valid=0, busy=0, out_data=0 next edge; a new rise afterwards completes normally.
- Argmax (DENSE_ARGMAX_EN):
  - Stimulus: outputs at element 17 and element 40 equal the maximum value 500.
  - Response: argmax_idx=17.

Source files
------------

// File: rtl/dense_pkg.sv
// dense_pkg: shared defaults, FSM state type and output ceiling for the dense post-processing stage.
package dense_pkg;
   localparam int DEF_DW    = 16;
   localparam int DEF_N     = 64;
   localparam int DEF_LANES = 8;
   localparam int OUT_MAX   = 2**(DEF_DW-1)-1;
   typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;
endpackage

// File: rtl/dense_bias_act_64_bias_relu_sat.sv
// bias_relu_sat: one element of bias add, ReLU, arithmetic shift and saturation (combinational).
module bias_relu_sat
   import dense_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int SHIFT = 4
) (
   input  logic signed [DW-1:0] psum,
   input  logic signed [DW-1:0] bias,
   output logic        [DW-1:0] act
);
   localparam logic [DW:0] MAX = (DW+1)'(DW == DEF_DW ? OUT_MAX : 2**(DW-1)-1);
   logic signed [DW:0] s;
   logic        [DW:0] r, q;
   always_comb begin
      s   = {psum[DW-1], psum} + {bias[DW-1], bias};
      r   = s[DW] ? '0 : s;
      q   = r >> SHIFT;
      act = (q > MAX) ? MAX[DW-1:0] : q[DW-1:0];
   end
endmodule

// File: rtl/dense_bias_act_64.sv
// dense_bias_act_64: captures a psum vector on in_finish rise, applies bias/ReLU/shift/saturate LANES at a time.
// Optional running argmax output is enabled by defining DENSE_ARGMAX_EN.
module dense_bias_act_64
   import dense_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int N     = DEF_N,
   parameter int LANES = DEF_LANES,
   parameter int SHIFT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_finish,
   input  logic [N*DW-1:0]   in_psum,
   input  logic [N*DW-1:0]   bias,
   output logic [N*DW-1:0]   out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
`ifdef DENSE_ARGMAX_EN
   output logic [$clog2(N)-1:0] argmax_idx,
`endif
   output logic              overrun
);
   localparam int G  = N / LANES;
   localparam int GW = G > 1 ? $clog2(G) : 1;
   localparam int IW = $clog2(N);
   state_t            state;
   logic              finish_q;
   logic [GW-1:0]     g;
   logic [N*DW-1:0]   psum_buf, bias_buf;
   logic [DW-1:0]     res [LANES];
   logic              rise;
   assign rise = in_finish & ~finish_q;
   assign busy = state != IDLE;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      bias_relu_sat #(.DW(DW), .SHIFT(SHIFT)) u_lane (
         .psum(psum_buf[(int'(g)*LANES+i)*DW +: DW]),
         .bias(bias_buf[(int'(g)*LANES+i)*DW +: DW]),
         .act (res[i])
      );
   end
`ifdef DENSE_ARGMAX_EN
   logic [DW-1:0] max_val, grp_max;
   logic [IW-1:0] grp_idx;
   // strict compare in ascending lane order keeps the lowest index on ties
   always_comb begin
      grp_max = '0;
      grp_idx = IW'(int'(g)*LANES);
      for (int i = 0; i < LANES; i++)
         if (res[i] > grp_max) begin
            grp_max = res[i];
            grp_idx = IW'(int'(g)*LANES+i);
         end
   end
   always_ff @(posedge clk)
      if (rst) begin
         max_val    <= '0;
         argmax_idx <= '0;
      end else if (state == IDLE && rise) begin
         max_val    <= '0;
         argmax_idx <= '0;
      end else if (state == PROC && grp_max > max_val) begin
         max_val    <= grp_max;
         argmax_idx <= grp_idx;
      end
`endif
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         finish_q  <= 1'b0;
         g         <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         finish_q <= in_finish;
         if (rise && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (rise) begin
               psum_buf <= in_psum;
               bias_buf <= bias;
               g        <= '0;
               state    <= PROC;
            end
            PROC: begin
               for (int i = 0; i < LANES; i++) out_data[(int'(g)*LANES+i)*DW +: DW] <= res[i];
               g <= g + 1'b1;
               if (g == GW'(G-1)) state <= DONE;
            end
            DONE: if (!out_valid) out_valid <= 1'b1;
               else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_dense_bias_act_64.sv
// tb_dense_bias_act_64: randomized self-checking bench against an arithmetic reference model.
module tb_dense_bias_act_64;
   localparam int DW = 16, N = 64, SHIFT = 4;
   logic clk = 1'b0, rst = 1'b1, in_finish = 1'b0, out_ready = 1'b0;
   logic [N*DW-1:0] in_psum = '0, bias = '0, out_data;
   logic out_valid, busy, overrun;
   int checks = 0, errors = 0;
`ifdef DENSE_ARGMAX_EN
   logic [5:0] argmax_idx;
`endif
   dense_bias_act_64 dut (
      .clk(clk), .rst(rst), .in_finish(in_finish), .in_psum(in_psum), .bias(bias),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef DENSE_ARGMAX_EN
      .argmax_idx(argmax_idx),
`endif
      .overrun(overrun)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [DW-1:0] ref_elem(input int p, input int b);
      int s;
      s = p + b;
      if (s < 0) s = 0;
      s = s / (1 << SHIFT);
      if (s > 2**(DW-1)-1) s = 2**(DW-1)-1;
      return DW'(s);
   endfunction
   function automatic logic [N*DW-1:0] ref_vec(input logic [N*DW-1:0] p, input logic [N*DW-1:0] b);
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++)
         r[i*DW +: DW] = ref_elem(int'($signed(p[i*DW +: DW])), int'($signed(b[i*DW +: DW])));
      return r;
   endfunction
   function automatic int ref_argmax(input logic [N*DW-1:0] v);
      int m = 0;
      for (int i = 1; i < N; i++) if (v[i*DW +: DW] > v[m*DW +: DW]) m = i;
      return m;
   endfunction
   function automatic logic [N*DW-1:0] rand_vec();
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
      return r;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // rise seen at edge T; returns cycles from T until out_valid (expected 9), -1 on timeout
   task automatic launch(input logic [N*DW-1:0] p, input logic [N*DW-1:0] b, output int lat);
      in_psum = p;
      bias = b;
      in_finish = 1'b1;
      tick();
      in_finish = 1'b0;
      in_psum = ~p;
      bias = rand_vec();
      check("busy_after_capture", busy, 1);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check("latency", lat, 9);
   endtask
   task automatic accept(input int stall, input logic [N*DW-1:0] exp);
      out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
         tick();
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, exp);
      end
      out_ready = 1'b1;
      tick();
      check("valid_drop", out_valid, 0);
      check("busy_drop", busy, 0);
      out_ready = 1'b0;
   endtask
   logic [N*DW-1:0] p, b, e;
   int lat, caps;
   logic prev;
   initial begin
      repeat (3) tick();
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_data", out_data, 0);
      rst = 1'b0;
      tick();
      for (int i = 0; i < N; i++) begin
         p[i*DW +: DW] = 16'd100;
         b[i*DW +: DW] = 16'd28;
         e[i*DW +: DW] = 16'd8;
      end
      out_ready = 1'b1;
      launch(p, b, lat);
      check("basic_data", out_data, e);
      check("basic_model", out_data, ref_vec(p, b));
      accept(0, e);
      p = rand_vec();
      b = rand_vec();
      p[0 +: DW] = -16'sd50;
      b[0 +: DW] = 16'sd10;
      p[DW +: DW] = 16'sd32767;
      b[DW +: DW] = 16'sd32767;
      launch(p, b, lat);
      check("relu_elem0", out_data[0 +: DW], 0);
      check("sat_elem1", out_data[DW +: DW], 4095);
      check("relu_sat_vec", out_data, ref_vec(p, b));
      accept($urandom_range(0, 3), ref_vec(p, b));
      for (int t = 0; t < 8; t++) begin
         p = rand_vec();
         b = rand_vec();
         if (t % 2 == 1)
            for (int i = 0; i < N; i++) b[i*DW +: DW] = DW'($urandom_range(0, 255));
         e = ref_vec(p, b);
         launch(p, b, lat);
         check("rand_data", out_data, e);
`ifdef DENSE_ARGMAX_EN
         check("rand_argmax", argmax_idx, ref_argmax(e));
`endif
         accept($urandom_range(0, 4), e);
      end
      in_psum = rand_vec();
      bias = rand_vec();
      in_finish = 1'b1;
      out_ready = 1'b1;
      caps = 0;
      prev = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (out_valid && !prev) caps++;
         prev = out_valid;
      end
      check("level_one_capture", caps, 1);
      check("level_overrun", overrun, 0);
      check("level_idle", busy, 0);
      in_finish = 1'b0;
      out_ready = 1'b0;
      tick();
      p = rand_vec();
      b = rand_vec();
      e = ref_vec(p, b);
      launch(p, b, lat);
      in_psum = rand_vec();
      bias = rand_vec();
      in_finish = 1'b1;
      tick();
      in_finish = 1'b0;
      check("overrun_set", overrun, 1);
      check("overrun_valid", out_valid, 1);
      check("overrun_data", out_data, e);
      accept(5, e);
      check("overrun_sticky", overrun, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("overrun_cleared", overrun, 0);
      tick();
      in_psum = rand_vec();
      bias = rand_vec();
      in_finish = 1'b1;
      tick();
      in_finish = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_data", out_data, 0);
      tick();
      p = rand_vec();
      b = rand_vec();
      e = ref_vec(p, b);
      launch(p, b, lat);
      check("after_rst_data", out_data, e);
      accept(0, e);
`ifdef DENSE_ARGMAX_EN
      for (int i = 0; i < N; i++) begin
         p[i*DW +: DW] = DW'($urandom_range(0, 7999));
         b[i*DW +: DW] = '0;
      end
      p[17*DW +: DW] = 16'd8000;
      p[40*DW +: DW] = 16'd8000;
      launch(p, b, lat);
      check("argmax_val", out_data[17*DW +: DW], 500);
      check("argmax_tie", argmax_idx, 17);
      accept(0, ref_vec(p, b));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
